// File: rtl/ntt_loader_pkg.sv
// Shared state encoding, default geometry and derived-width helpers for the NTT input loader.
// Wrapper address width is fixed by the wrapper: max(LOGN, 9) + 1.
package ntt_loader_pkg;

  localparam int LOGQ_DEF = 64;
  localparam int LOGN_DEF = 4;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic int calc_n(input int logn);
    return 1 << logn;
  endfunction

  function automatic int calc_aw(input int logn);
    return ((logn < 9) ? 9 : logn) + 1;
  endfunction

  localparam int N    = calc_n(LOGN_DEF);
  localparam int HALF = N / 2;
  localparam int AW   = calc_aw(LOGN_DEF);
  localparam int IDXW = LOGN_DEF - 1;

endpackage

// File: rtl/ntt_loader_bank.sv
// Half-polynomial coefficient store: one write port, one registered read port (1-cycle latency).
// The read register clears on reset; the array itself is never reset.
module ntt_loader_bank #(
  parameter int W   = 64,
  parameter int AWB = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [AWB-1:0] waddr,
  input  logic [W-1:0]   wdata,
  input  logic [AWB-1:0] raddr,
  output logic [W-1:0]   rdata
);
  localparam int DEPTH = 2 ** AWB;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/ntt_input_loader.sv
// Loads one N-word polynomial into two half-banks, starts the wrapper, serves (coef[a], coef[a+N/2]) at 1-cycle latency.
// Define NTT_LOADER_PINGPONG_EN for two buffers so the next frame loads while the wrapper runs.
module ntt_input_loader
  import ntt_loader_pkg::*;
#(
  parameter int LOGQ = LOGQ_DEF,
  parameter int LOGN = LOGN_DEF,
  localparam int ADDR_W = calc_aw(LOGN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [LOGQ-1:0]   s_data,
  input  logic              s_last,
  input  logic              s_intt,
  input  logic [LOGQ-1:0]   q_in,
  output logic              ntt_start,
  output logic              ntt_intt,
  output logic [LOGQ-1:0]   ntt_q,
  input  logic [ADDR_W-1:0] ntt_read_address,
  output logic [LOGQ-1:0]   ntt_data_in_0,
  output logic [LOGQ-1:0]   ntt_data_in_1,
  input  logic              ntt_finish,
  output logic              frame_done,
  output logic              err_len
);
  localparam int IDX_W = LOGN - 1;

  logic [1:0]       state;
  logic [LOGN-1:0]  cnt;
  logic             accept;
  logic             last_beat;
  logic             early_last;
  logic [IDX_W-1:0] rd_idx;
  logic             unused_addr_hi;

  assign accept     = s_valid && s_ready;
  assign last_beat  = accept && (&cnt);
  assign early_last = accept && s_last && !last_beat;
  assign rd_idx     = ntt_read_address[IDX_W-1:0];
  assign unused_addr_hi = ^ntt_read_address[ADDR_W-1:IDX_W];

`ifndef NTT_LOADER_PINGPONG_EN

  // The count's MSB picks the half-bank, its low bits the word within it.
  ntt_loader_bank #(.W(LOGQ), .AWB(IDX_W)) u_bank0 (
    .clk(clk), .rst(rst), .we(accept && !cnt[LOGN-1]), .waddr(cnt[IDX_W-1:0]),
    .wdata(s_data), .raddr(rd_idx), .rdata(ntt_data_in_0)
  );

  ntt_loader_bank #(.W(LOGQ), .AWB(IDX_W)) u_bank1 (
    .clk(clk), .rst(rst), .we(accept && cnt[LOGN-1]), .waddr(cnt[IDX_W-1:0]),
    .wdata(s_data), .raddr(rd_idx), .rdata(ntt_data_in_1)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      s_ready    <= 1'b0;
      ntt_start  <= 1'b0;
      ntt_intt   <= 1'b0;
      ntt_q      <= '0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      err_len    <= early_last || (last_beat && !s_last);
      frame_done <= 1'b0;
      if (accept) cnt <= (last_beat || early_last) ? '0 : cnt + LOGN'(1);
      if (accept && cnt == '0) begin
        ntt_intt <= s_intt;
        ntt_q    <= q_in;
      end
      case (state)
        ST_LOAD: begin
          s_ready <= !last_beat;
          if (last_beat) begin
            state     <= ST_RUN;
            ntt_start <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ntt_finish) begin
            state      <= ST_GAP;
            ntt_start  <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        ST_GAP: begin
          // One idle cycle so the wrapper always sees a fresh start edge.
          state   <= ST_LOAD;
          s_ready <= 1'b1;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

`else

  logic [1:0]      full;
  logic [1:0]      full_set;
  logic [1:0]      full_clr;
  logic [1:0]      full_nxt;
  logic            wr_buf;
  logic            rd_buf;
  logic            rd_sel;
  logic [1:0]      buf_intt;
  logic [LOGQ-1:0] buf_q [2];
  logic [LOGQ-1:0] rd0_a, rd1_a, rd0_b, rd1_b;

  // Fill and service both alternate A/B, so with nothing pending wr_buf == rd_buf.
  assign full_set = last_beat ? (wr_buf ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr = (state == ST_RUN && ntt_finish) ? (rd_buf ? 2'b10 : 2'b01) : 2'b00;
  assign full_nxt = (full | full_set) & ~full_clr;

  ntt_loader_bank #(.W(LOGQ), .AWB(IDX_W)) u_bank_a0 (
    .clk(clk), .rst(rst), .we(accept && !wr_buf && !cnt[LOGN-1]), .waddr(cnt[IDX_W-1:0]),
    .wdata(s_data), .raddr(rd_idx), .rdata(rd0_a)
  );

  ntt_loader_bank #(.W(LOGQ), .AWB(IDX_W)) u_bank_a1 (
    .clk(clk), .rst(rst), .we(accept && !wr_buf && cnt[LOGN-1]), .waddr(cnt[IDX_W-1:0]),
    .wdata(s_data), .raddr(rd_idx), .rdata(rd1_a)
  );

  ntt_loader_bank #(.W(LOGQ), .AWB(IDX_W)) u_bank_b0 (
    .clk(clk), .rst(rst), .we(accept && wr_buf && !cnt[LOGN-1]), .waddr(cnt[IDX_W-1:0]),
    .wdata(s_data), .raddr(rd_idx), .rdata(rd0_b)
  );

  ntt_loader_bank #(.W(LOGQ), .AWB(IDX_W)) u_bank_b1 (
    .clk(clk), .rst(rst), .we(accept && wr_buf && cnt[LOGN-1]), .waddr(cnt[IDX_W-1:0]),
    .wdata(s_data), .raddr(rd_idx), .rdata(rd1_b)
  );

  // rd_sel trails rd_buf by a cycle to line up with the registered bank reads.
  assign ntt_data_in_0 = rd_sel ? rd0_b : rd0_a;
  assign ntt_data_in_1 = rd_sel ? rd1_b : rd1_a;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      s_ready    <= 1'b0;
      ntt_start  <= 1'b0;
      ntt_intt   <= 1'b0;
      ntt_q      <= '0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      full       <= 2'b00;
      wr_buf     <= 1'b0;
      rd_buf     <= 1'b0;
      rd_sel     <= 1'b0;
      buf_intt   <= 2'b00;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      err_len    <= early_last || (last_beat && !s_last);
      frame_done <= 1'b0;
      full       <= full_nxt;
      s_ready    <= !(&full_nxt);
      rd_sel     <= rd_buf;
      if (accept) cnt <= (last_beat || early_last) ? '0 : cnt + LOGN'(1);
      if (accept && cnt == '0) begin
        buf_intt[wr_buf] <= s_intt;
        buf_q[wr_buf]    <= q_in;
      end
      if (last_beat) wr_buf <= !wr_buf;
      case (state)
        ST_LOAD, ST_GAP: begin
          if (full_nxt[rd_buf]) begin
            state     <= ST_RUN;
            ntt_start <= 1'b1;
            ntt_intt  <= buf_intt[rd_buf];
            ntt_q     <= buf_q[rd_buf];
          end else begin
            state <= ST_LOAD;
          end
        end
        ST_RUN: begin
          if (ntt_finish) begin
            state      <= ST_GAP;
            ntt_start  <= 1'b0;
            frame_done <= 1'b1;
            rd_buf     <= !rd_buf;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_ntt_input_loader.sv
// Bench for ntt_input_loader (LOGN=4): directed read table, corner sequences, randomized frames vs array model.
module tb_ntt_input_loader;
  import ntt_loader_pkg::*;

`ifdef NTT_LOADER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, s_valid, s_ready, s_last, s_intt;
  logic          ntt_start, ntt_intt, ntt_finish, frame_done, err_len;
  logic [63:0]   s_data, q_in, ntt_q, ntt_data_in_0, ntt_data_in_1;
  logic [AW-1:0] ntt_read_address;

  always #5 clk = ~clk;

  ntt_input_loader #(.LOGQ(64), .LOGN(4)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_intt(s_intt), .q_in(q_in), .ntt_start(ntt_start),
    .ntt_intt(ntt_intt), .ntt_q(ntt_q), .ntt_read_address(ntt_read_address),
    .ntt_data_in_0(ntt_data_in_0), .ntt_data_in_1(ntt_data_in_1),
    .ntt_finish(ntt_finish), .frame_done(frame_done), .err_len(err_len)
  );

  typedef struct {
    int          addr;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } rd_vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] frame [N];
  logic [63:0] model [N];
  rd_vec_t     vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_frame(input int nbeats, input int last_at, input logic intt,
                            input logic [63:0] q, input bit gaps, output int cycles);
    int   sent = 0;
    logic rdy;
    cycles = 0;
    while (sent < nbeats && cycles < 400) begin
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = frame[sent];
      s_last  = (sent == last_at);
      s_intt  = intt;
      q_in    = q;
      rdy     = s_ready;
      tick();
      cycles++;
      if (s_valid && rdy) sent++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("load_beats", 64'(sent), 64'(nbeats));
  endtask

  // Expected pair comes straight from the stored polynomial: (p[a mod N/2], p[a mod N/2 + N/2]).
  task automatic rd_chk(input int a);
    int i = a % HALF;
    ntt_read_address = AW'(a);
    tick();
    chk("rd_lo", ntt_data_in_0, model[i]);
    chk("rd_hi", ntt_data_in_1, model[i + HALF]);
  endtask

  task automatic do_finish();
    ntt_finish = 1'b1;
    tick();
    ntt_finish = 1'b0;
    chk("fin_start", 64'(ntt_start), 64'(0));
    chk("fin_done", 64'(frame_done), 64'(1));
    chk("gap_ready", 64'(s_ready), 64'(PP));
    tick();
    chk("post_done", 64'(frame_done), 64'(0));
    chk("post_ready", 64'(s_ready), 64'(1));
    chk("post_start", 64'(ntt_start), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          bad;
    logic        ri;
    logic [63:0] rq;
    logic [63:0] q1;

    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_intt = 1'b0; s_data = '0;
    q_in = '0; ntt_finish = 1'b0; ntt_read_address = '0;
    tick(); tick();
    chk("rst_ready", 64'(s_ready), 64'(0));
    chk("rst_start", 64'(ntt_start), 64'(0));
    chk("rst_intt", 64'(ntt_intt), 64'(0));
    chk("rst_q", ntt_q, 64'(0));
    chk("rst_d0", ntt_data_in_0, 64'(0));
    chk("rst_d1", ntt_data_in_1, 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_err", 64'(err_len), 64'(0));
    rst = 1'b1;
    tick();
    chk("rel_ready", 64'(s_ready), 64'(1));
    chk("rel_start", 64'(ntt_start), 64'(0));

    // Basic frame with a directed read table
    for (int i = 0; i < N; i++) frame[i] = 64'h10 + 64'(i);
    send_frame(16, 15, 1'b0, 64'hFFFFFFFF00000001, 1'b0, cyc);
    chk("basic_start", 64'(ntt_start), 64'(1));
    chk("basic_ready", 64'(s_ready), 64'(PP));
    chk("basic_err", 64'(err_len), 64'(0));
    chk("basic_q", ntt_q, 64'hFFFFFFFF00000001);
    chk("basic_intt", 64'(ntt_intt), 64'(0));
    for (int i = 0; i < N; i++) model[i] = frame[i];
    vecs[0] = '{3, 64'h13, 64'h1B};
    vecs[1] = '{0, 64'h10, 64'h18};
    vecs[2] = '{7, 64'h17, 64'h1F};
    vecs[3] = '{11, 64'h13, 64'h1B};
    vecs[4] = '{'h3F5, 64'h15, 64'h1D};
    vecs[5] = '{8, 64'h10, 64'h18};
    for (int v = 0; v < 6; v++) begin
      ntt_read_address = AW'(vecs[v].addr);
      tick();
      chk($sformatf("vec%0d_lo", v), ntt_data_in_0, vecs[v].exp0);
      chk($sformatf("vec%0d_hi", v), ntt_data_in_1, vecs[v].exp1);
    end

    // Wrapper holds off finish for 100 cycles
    bad = 0;
    repeat (100) begin
      tick();
      if (ntt_start !== 1'b1 || s_ready !== PP) bad++;
    end
    chk("hold_run", 64'(bad), 64'(0));
    chk("hold_q", ntt_q, 64'hFFFFFFFF00000001);
    do_finish();

    // Early s_last on beat 5 discards the frame
    for (int i = 0; i < N; i++) frame[i] = 64'hA0 + 64'(i);
    send_frame(6, 5, 1'b1, 64'h1234, 1'b0, cyc);
    chk("early_err", 64'(err_len), 64'(1));
    chk("early_start", 64'(ntt_start), 64'(0));
    chk("early_ready", 64'(s_ready), 64'(1));
    tick();
    chk("early_err_end", 64'(err_len), 64'(0));
    chk("early_start2", 64'(ntt_start), 64'(0));
    for (int i = 0; i < N; i++) frame[i] = 64'hB00 + 64'(i);
    send_frame(16, 15, 1'b1, 64'h5555, 1'b0, cyc);
    chk("reload_start", 64'(ntt_start), 64'(1));
    chk("reload_intt", 64'(ntt_intt), 64'(1));
    chk("reload_q", ntt_q, 64'h5555);
    for (int i = 0; i < N; i++) model[i] = frame[i];
    rd_chk(0);
    rd_chk(5);
    do_finish();

    // Missing s_last: frame kept, err_len flagged
    for (int i = 0; i < N; i++) frame[i] = {$urandom, $urandom};
    send_frame(16, -1, 1'b0, 64'h77, 1'b0, cyc);
    chk("miss_err", 64'(err_len), 64'(1));
    chk("miss_start", 64'(ntt_start), 64'(1));
    for (int i = 0; i < N; i++) model[i] = frame[i];
    rd_chk(2);
    chk("miss_err_end", 64'(err_len), 64'(0));
    do_finish();

    // Reset in the middle of RUN
    for (int i = 0; i < N; i++) frame[i] = {$urandom, $urandom};
    send_frame(16, 15, 1'b1, 64'h99, 1'b0, cyc);
    chk("pre_rst_start", 64'(ntt_start), 64'(1));
    rst = 1'b0;
    tick();
    chk("mid_rst_start", 64'(ntt_start), 64'(0));
    chk("mid_rst_ready", 64'(s_ready), 64'(0));
    chk("mid_rst_q", ntt_q, 64'(0));
    rst = 1'b1;
    tick();
    chk("post_rst_ready", 64'(s_ready), 64'(1));
    bad = 0;
    repeat (5) begin
      tick();
      if (ntt_start !== 1'b0) bad++;
    end
    chk("post_rst_idle", 64'(bad), 64'(0));
    for (int i = 0; i < N; i++) frame[i] = {$urandom, $urandom};
    send_frame(16, 15, 1'b0, 64'hABC, 1'b1, cyc);
    chk("rst_reload_start", 64'(ntt_start), 64'(1));
    for (int i = 0; i < N; i++) model[i] = frame[i];
    rd_chk(9);
    do_finish();

    // Randomized frames with valid gaps
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) frame[i] = {$urandom, $urandom};
      ri = 1'($urandom_range(0, 1));
      rq = {$urandom, $urandom};
      send_frame(16, 15, ri, rq, 1'b1, cyc);
      chk("rnd_start", 64'(ntt_start), 64'(1));
      chk("rnd_err", 64'(err_len), 64'(0));
      chk("rnd_q", ntt_q, rq);
      chk("rnd_intt", 64'(ntt_intt), 64'(ri));
      for (int i = 0; i < N; i++) model[i] = frame[i];
      repeat (4) rd_chk(int'($urandom_range(0, 1023)));
      repeat ($urandom_range(0, 20)) tick();
      chk("rnd_hold_start", 64'(ntt_start), 64'(1));
      do_finish();
    end

`ifdef NTT_LOADER_PINGPONG_EN
    // Second frame loads while the first is being served
    for (int i = 0; i < N; i++) frame[i] = 64'hC00 + 64'(i);
    q1 = 64'h1111;
    send_frame(16, 15, 1'b0, q1, 1'b0, cyc);
    chk("pp_start1", 64'(ntt_start), 64'(1));
    for (int i = 0; i < N; i++) model[i] = frame[i];
    for (int i = 0; i < N; i++) frame[i] = 64'hD00 + 64'(i);
    send_frame(16, 15, 1'b1, 64'h2222, 1'b0, cyc);
    chk("pp_no_stall", 64'(cyc), 64'(16));
    chk("pp_both_full", 64'(s_ready), 64'(0));
    chk("pp_q_stable", ntt_q, q1);
    rd_chk(4);
    ntt_finish = 1'b1;
    tick();
    ntt_finish = 1'b0;
    chk("pp_fin_start", 64'(ntt_start), 64'(0));
    chk("pp_fin_done", 64'(frame_done), 64'(1));
    tick();
    chk("pp_restart", 64'(ntt_start), 64'(1));
    chk("pp_q2", ntt_q, 64'h2222);
    chk("pp_intt2", 64'(ntt_intt), 64'(1));
    for (int i = 0; i < N; i++) model[i] = frame[i];
    rd_chk(1);
    rd_chk(6);
    do_finish();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
